axis_rr_pkt_arbiter: RTL
========================

Name: axis_rr_pkt_arbiter

Overview:
- N-input AXI-Stream packet arbiter: round-robin grant, locked for a whole packet (through the tlast beat), merged onto one master stream.
- Sits between the per-source stream producers (s0a/s0b-style ports) and the single shared m0k-style consumer.
- Registered output slice gives full throughput inside a packet with stable m_axis_* under backpressure.

Parameters:
- N, 2, number of slave stream inputs (2..16).
- DATA_W, 32, tdata width per stream.
- ID_W, $clog2(N) (minimum 1), width of the grant index and of the optional tid output.

Ports:
- axis_aclk  in  1  single clock, all logic rising-edge.
- axis_areset  in  1  asynchronous, active-high reset.
- s_axis_tdata  in  N*DATA_W  source i occupies bits [i*DATA_W +: DATA_W].
- s_axis_tvalid  in  N  per-source valid.
- s_axis_tlast  in  N  per-source end of packet.
- s_axis_tready  out  N  per-source ready.
- m_axis_tdata  out  DATA_W  merged data.
- m_axis_tvalid  out  1  merged valid.
- m_axis_tlast  out  1  merged tlast.
- m_axis_tready  in  1  downstream ready.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, grant=0, rr_ptr=0.
  - m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0.
  - s_axis_tready=0 for every source.
- FSM states: IDLE, BUSY.
- IDLE:
  - If any s_axis_tvalid is set, grant = first i with tvalid set, searching i = rr_ptr, rr_ptr+1, ... N-1, 0, ... (modulo N).
  - On the same edge: rr_ptr <= (grant+1) mod N (wraps N-1 -> 0), go to BUSY.
  - No valid: stay in IDLE, rr_ptr unchanged.
- BUSY:
  - s_axis_tready[grant] = (!m_axis_tvalid || m_axis_tready). Every other tready = 0.
  - s_axis_tready depends combinationally on m_axis_tready only; there is no comb path from s_axis_tvalid.
  - Accept = s_axis_tvalid[grant] && s_axis_tready[grant].
  - On accept: m_axis_tdata/tlast <= source beat, m_axis_tvalid <= 1.
  - On an accepted beat with tlast=1: go to IDLE.
- Output slice:
  - If m_axis_tvalid && m_axis_tready and there is no accept that cycle: m_axis_tvalid <= 0.
  - While m_axis_tvalid=1 && m_axis_tready=0, tdata/tlast are held stable.
- Latency:
  - Source tvalid rises in cycle t while in IDLE: grant is registered at edge t+1, tready is high during cycle t+1.
  - Beat appears on m_axis at edge t+2.
  - One bubble (IDLE) cycle follows every packet. Throughput inside a packet: 1 beat/cycle.
- Boundaries:
  - Single-beat packet (tlast on first beat): BUSY lasts exactly one accept, then IDLE.
  - Granted source drops tvalid mid-packet: grant stays held indefinitely. No timeout, no preemption.
  - Requests from other sources during BUSY: ignored until IDLE. A source never loses a pending request.
  - All N sources valid continuously: grants rotate strictly 0,1,...,N-1,0. Each source gets one packet per round.
  - Downstream stall: no beat is lost or duplicated. tready to the source falls in the same cycle m_axis_tready=0 with m_axis_tvalid=1.
  - Reset asserted mid-packet: outputs clear immediately (async). The partial packet is dropped and no tlast is emitted.

Optional Feature:
- Macro: ARB_TID_EN.
- Defined:
  - Adds output port m_axis_tid [ID_W-1:0].
  - Registered alongside tdata with the grant index of the beat's source; held stable under backpressure.
  - Reset value 0.
- Not defined: port and register absent; behaviour otherwise identical.

Test Plan:
- Reset behaviour: assert axis_areset mid-clock-period -> m_axis_tvalid=0 and all s_axis_tready=0 within the same cycle. Release, drive source 0 with 1..10, tlast on 10 -> m_axis carries 1..10 in order, tlast only on 10, first beat at edge t+2.
- Full throughput: source 1, 10-beat packet, m_axis_tready=1 -> 10 consecutive m_axis_tvalid cycles, then 1 idle cycle.
- Fairness (N=2): sources 0 and 1 both present 3 packets of 4 beats simultaneously -> packet order 0,1,0,1,0,1, and no interleaving of beats within any packet.
- Pointer wrap (N=4): source 3 granted first, then sources 0 and 3 both request -> source 0 is granted next. Also a single-beat packet on source 2 -> exactly one m_axis beat with tlast=1.
- Backpressure: toggle m_axis_tready 1,0,0,1,0,1 during a packet from source 0 of 5,6,7,8 -> m_axis_tdata stable while stalled, sequence 5,6,7,8 exact, no extra beats. With ARB_TID_EN, m_axis_tid=0 throughout.
- Reset mid-packet: reset after beat 3 of 10 -> no further m_axis beats. After release, a new packet from source 1 is delivered intact with rr_ptr restarted at 0.

Source files
------------

// File: rtl/axis_rr_pkt_arbiter.sv
// -----------------------------------------------------------------------------
// axis_rr_pkt_arbiter
//
// Round-robin AXI-Stream packet arbiter. It merges N slave streams onto one
// master stream. Once a source is granted, the grant stays with that source
// until its tlast beat is accepted. The master side is a registered slice, so
// data moves at one beat per cycle inside a packet, and m_axis_* hold steady
// while the consumer applies backpressure.
//
// Optional feature: define ARB_TID_EN to add m_axis_tid. This output carries
// the index of the source that produced each beat.
//
// Parameters:
//   N       number of slave inputs (2..16)
//   DATA_W  tdata width
//   ID_W    width of the grant index and of m_axis_tid
//
// Ports:
//   axis_aclk       clock; all logic runs on the rising edge
//   axis_areset     asynchronous, active-high reset
//   s_axis_tdata    N*DATA_W; source i is in [i*DATA_W +: DATA_W]
//   s_axis_tvalid   per-source valid
//   s_axis_tlast    per-source end of packet
//   s_axis_tready   per-source ready (only the granted source, only in BUSY)
//   m_axis_tdata    merged data (registered)
//   m_axis_tvalid   merged valid (registered)
//   m_axis_tlast    merged tlast (registered)
//   m_axis_tready   downstream ready
//   m_axis_tid      source index of the current beat (ARB_TID_EN only)
// -----------------------------------------------------------------------------
module axis_rr_pkt_arbiter #(
  parameter int N      = 2,
  parameter int DATA_W = 32,
  parameter int ID_W   = (N > 1) ? $clog2(N) : 1
) (
  input  logic                axis_aclk,
  input  logic                axis_areset,
  input  logic [N*DATA_W-1:0] s_axis_tdata,
  input  logic [N-1:0]        s_axis_tvalid,
  input  logic [N-1:0]        s_axis_tlast,
  output logic [N-1:0]        s_axis_tready,
  output logic [DATA_W-1:0]   m_axis_tdata,
  output logic                m_axis_tvalid,
  output logic                m_axis_tlast,
  input  logic                m_axis_tready
`ifdef ARB_TID_EN
  ,
  output logic [ID_W-1:0]     m_axis_tid
`endif
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state;
  logic [ID_W-1:0]   grant;
  logic [ID_W-1:0]   rr_ptr;

  logic [2*N-1:0]    req_dbl;
  logic [N-1:0]      req_rot;
  logic              any_valid;
  logic [ID_W-1:0]   pick;
  logic [ID_W-1:0]   pick_next;
  int                pick_sum;

  logic              slot_free;
  logic              sel_valid;
  logic              sel_last;
  logic [DATA_W-1:0] sel_data;
  logic              accept;

  // The request vector is rotated so that bit 0 is the rr_ptr source. The
  // lowest set bit of the rotated vector is then the next source in
  // round-robin order. Adding rr_ptr back maps that bit to a real index.
  // NOTE: every always_comb output gets a default before any branch, so no
  // path through the block can leave a latch.
  always_comb begin
    req_dbl   = {s_axis_tvalid, s_axis_tvalid} >> rr_ptr;
    req_rot   = req_dbl[N-1:0];
    any_valid = 1'b0;
    pick_sum  = 0;
    for (int k = 0; k < N; k++) begin
      if (!any_valid && req_rot[k]) begin
        any_valid = 1'b1;
        pick_sum  = int'(rr_ptr) + k;
      end
    end
    if (pick_sum >= N) pick_sum = pick_sum - N;
    pick      = ID_W'(pick_sum);
    pick_next = (pick == ID_W'(N - 1)) ? '0 : pick + 1'b1;
  end

  // Source mux for the granted input.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < N; i++) begin
      if (grant == ID_W'(i)) begin
        sel_valid = s_axis_tvalid[i];
        sel_last  = s_axis_tlast[i];
        sel_data  = s_axis_tdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // Ready depends only on the state and on the output slice. It has no path
  // from any s_axis_tvalid.
  assign slot_free = !m_axis_tvalid || m_axis_tready;

  always_comb begin
    s_axis_tready = '0;
    if (state == BUSY) s_axis_tready[grant] = slot_free;
  end

  assign accept = (state == BUSY) && sel_valid && slot_free;

  // NOTE: all state is updated with non-blocking assignments. This lets every
  // register sample the values from before the edge, regardless of order.
  always_ff @(posedge axis_aclk or posedge axis_areset) begin
    if (axis_areset) begin
      state         <= IDLE;
      grant         <= '0;
      rr_ptr        <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
`ifdef ARB_TID_EN
      m_axis_tid    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            grant  <= pick;
            rr_ptr <= pick_next;
            state  <= BUSY;
          end
        end
        BUSY: begin
          if (accept && sel_last) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // Output slice. Load on accept, otherwise drain once the consumer takes
      // the beat. Data and tlast only change on accept, so they stay stable
      // while the consumer stalls.
      if (accept) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= sel_data;
        m_axis_tlast  <= sel_last;
`ifdef ARB_TID_EN
        m_axis_tid    <= grant;
`endif
      end else if (m_axis_tvalid && m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end

endmodule
